// File: rtl/xor_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : xor_rr_sched
// Purpose  : Round-robin sharing of one external XOR unit between two lanes,
//            with result cross-check and a saturating mismatch counter.
// Revision : 1.0
// ============================================================================
module xor_rr_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] xu_a,
    output logic [WIDTH-1:0] xu_b,
    input  logic [WIDTH-1:0] xu_c,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_c,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_c,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last;
    logic               r_lane;
    logic [WIDTH-1:0]   r_cap_a;
    logic [WIDTH-1:0]   r_cap_b;
    logic [WIDTH-1:0]   r_rsp0_c;
    logic [WIDTH-1:0]   r_rsp1_c;
    logic               r_err;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_idle;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_rsp_hs;
    logic               w_mismatch;

    // On contention the lane that was not served last wins.
    assign w_idle     = (r_state == S_IDLE);
    assign w_gnt0     = w_idle & req0_valid & (~req1_valid | r_last);
    assign w_gnt1     = w_idle & req1_valid & (~req0_valid | ~r_last);
    assign w_rsp_hs   = r_lane ? rsp1_ready : rsp0_ready;
    assign w_mismatch = (r_state == S_ISSUE) && (xu_c != (r_cap_a ^ r_cap_b));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt0 | w_gnt1) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_lane  <= 1'b0;
            r_cap_a <= '0;
            r_cap_b <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0) begin
                r_cap_a <= req0_a;
                r_cap_b <= req0_b;
                r_lane  <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_gnt1) begin
                r_cap_a <= req1_a;
                r_cap_b <= req1_b;
                r_lane  <= 1'b1;
                r_last  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp0_c <= '0;
            r_rsp1_c <= '0;
        end else if (r_state == S_ISSUE) begin
            if (r_lane) r_rsp1_c <= xu_c;
            else        r_rsp0_c <= xu_c;
        end
    end

    // A clear in the same cycle as a mismatch wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
            if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign xu_a       = r_cap_a;
    assign xu_b       = r_cap_b;
    assign rsp0_valid = (r_state == S_RESP) & ~r_lane;
    assign rsp1_valid = (r_state == S_RESP) &  r_lane;
    assign rsp0_c     = r_rsp0_c;
    assign rsp1_c     = r_rsp1_c;
    assign err        = r_err;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_xor_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_rr_sched
// Purpose  : Directed self-checking bench for xor_rr_sched.
// Revision : 1.0
// ============================================================================
module tb_xor_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic       err_clr = 1'b0;
    logic       fault = 1'b0;

    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, err;
    logic [7:0] xu_a, xu_b, xu_c, rsp0_c, rsp1_c, err_cnt;

    logic       d2_req0_ready, d2_req1_ready, d2_rsp0_valid, d2_rsp1_valid, d2_err;
    logic [7:0] d2_xu_a, d2_xu_b, d2_xu_c, d2_rsp0_c, d2_rsp1_c;
    logic [1:0] d2_err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign xu_c    = fault ? (xu_a & xu_b) : (xu_a ^ xu_b);
    assign d2_xu_c = fault ? (d2_xu_a & d2_xu_b) : (d2_xu_a ^ d2_xu_b);

    xor_rr_sched #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .xu_a(xu_a), .xu_b(xu_b), .xu_c(xu_c),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c),
        .err(err), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    xor_rr_sched #(.WIDTH(8), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(d2_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(d2_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .xu_a(d2_xu_a), .xu_b(d2_xu_b), .xu_c(d2_xu_c),
        .rsp0_valid(d2_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(d2_rsp0_c),
        .rsp1_valid(d2_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(d2_rsp1_c),
        .err(d2_err), .err_cnt(d2_err_cnt), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Full transaction on one lane with the response consumer ready.
    task automatic send(input bit lane, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_c);
        @(negedge clk);
        if (lane) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else      begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        #1;
        chk("send_ready", lane ? req1_ready : req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("send_xu_a", xu_a, a);
        chk("send_xu_b", xu_b, b);
        @(negedge clk);
        chk("send_rsp_valid", lane ? rsp1_valid : rsp0_valid, 1);
        chk("send_rsp_c", lane ? rsp1_c : rsp0_c, exp_c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        chk("rst_rsp_c", {rsp0_c, rsp1_c}, 0);
        chk("rst_xu", {xu_a, xu_b}, 0);
        chk("rst_err", {err, err_cnt}, 0);
        rst_n = 1'b1;

        // Single lane 0
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h5A; req0_b = 8'h0F;
        #1;
        chk("l0_req0_ready", req0_ready, 1);
        chk("l0_req1_ready", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("l0_xu_a", xu_a, 8'h5A);
        chk("l0_xu_b", xu_b, 8'h0F);
        @(negedge clk);
        chk("l0_rsp0_valid", rsp0_valid, 1);
        chk("l0_rsp0_c", rsp0_c, 8'h55);
        chk("l0_lane1_quiet", {rsp1_valid, rsp1_c}, 0);
        @(negedge clk);
        chk("l0_rsp0_done", rsp0_valid, 0);

        // Alternation from reset with both lanes held valid
        do_reset();
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("alt_req1_ready", req1_ready, (i % 2 == 1) ? 1 : 0);
            @(negedge clk);
            chk("alt_issue_ready", {req0_ready, req1_ready}, 0);
            @(negedge clk);
            if (i % 2 == 0) begin
                chk("alt_rsp0", {rsp0_valid, rsp1_valid}, 2'b10);
                chk("alt_rsp0_c", rsp0_c, 8'h03);
            end else begin
                chk("alt_rsp1", {rsp0_valid, rsp1_valid}, 2'b01);
                chk("alt_rsp1_c", rsp1_c, 8'h30);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Response backpressure on lane 1
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55;
        #1;
        chk("bp_req1_ready", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h0F;
        chk("bp_issue_req0_ready", req0_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp1_valid", rsp1_valid, 1);
            chk("bp_rsp1_c", rsp1_c, 8'hFF);
            chk("bp_req0_blocked", req0_ready, 0);
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
        chk("bp_rsp1_released", rsp1_valid, 0);
        chk("bp_req0_ready", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("bp_xu_a", xu_a, 8'h33);
        @(negedge clk);
        chk("bp_rsp0_valid", rsp0_valid, 1);
        chk("bp_rsp0_c", rsp0_c, 8'h3C);
        rsp1_ready = 1'b1;

        // Faulty shared unit: result is a & b
        fault = 1'b1;
        send(1'b0, 8'h0F, 8'h03, 8'h03);
        send(1'b0, 8'hF0, 8'h30, 8'h30);
        send(1'b0, 8'hFF, 8'h01, 8'h01);
        chk("flt_err", err, 1);
        chk("flt_err_cnt", err_cnt, 3);
        chk("flt_sat_cnt3", d2_err_cnt, 3);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_sat_cnt", d2_err_cnt, 0);
        for (int i = 0; i < 5; i++) send(1'b1, 8'hC0, 8'h40 + 8'(i), 8'h40);
        chk("flt5_err_cnt", err_cnt, 5);
        chk("flt5_sat_cnt", d2_err_cnt, 3);
        chk("flt5_sat_err", d2_err, 1);

        // Clear coinciding with a mismatch in ISSUE
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'h03;
        @(negedge clk);
        req0_valid = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clrmm_err", err, 0);
        chk("clrmm_err_cnt", err_cnt, 0);
        chk("clrmm_sat_cnt", d2_err_cnt, 0);
        fault = 1'b0;

        // Reset during ISSUE of lane 1
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 8'h77; req1_b = 8'h11;
        #1;
        chk("rmid_req1_ready", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rmid_rsp1_valid", rsp1_valid, 0);
        chk("rmid_rsp_c", {rsp0_c, rsp1_c}, 0);
        chk("rmid_xu", {xu_a, xu_b}, 0);
        chk("rmid_err", {err, err_cnt}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rmid_no_rsp", {rsp0_valid, rsp1_valid}, 0);
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01;
        req1_valid = 1'b1; req1_a = 8'h02; req1_b = 8'h02;
        #1;
        chk("rmid_contend_req0", req0_ready, 1);
        chk("rmid_contend_req1", req1_ready, 0);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xor_rr_sched.md
# xor_rr_sched

Round-robin scheduler that shares one external two-input XOR unit (the `bar`-style `c = a ^ b` cell) between two requester lanes. It accepts operand pairs over valid/ready handshakes, issues them one at a time to the shared unit, and returns each result on the originating lane's response port. It also cross-checks every result against an internal reference XOR and counts mismatches, so a bound checker cell can be trusted.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width in bits.
- `CNT_W`, 8: width of the mismatch counter.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `req0_valid` input 1: lane 0 offers an operand pair.
- `req0_ready` output 1: lane 0 pair accepted this cycle.
- `req0_a` input WIDTH: lane 0 operand a.
- `req0_b` input WIDTH: lane 0 operand b.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as lane 0, for lane 1.
- `xu_a` output WIDTH: operand a driven to the shared unit.
- `xu_b` output WIDTH: operand b driven to the shared unit.
- `xu_c` input WIDTH: shared unit result; combinational from `xu_a`/`xu_b`.
- `rsp0_valid` output 1: lane 0 result available.
- `rsp0_ready` input 1: lane 0 consumer accepts the result.
- `rsp0_c` output WIDTH: lane 0 result.
- `rsp1_valid`, `rsp1_ready`, `rsp1_c`: same as lane 0, for lane 1.
- `err` output 1: sticky flag, set on any result mismatch.
- `err_cnt` output CNT_W: saturating count of mismatches.
- `err_clr` input 1: synchronous clear of `err` and `err_cnt`.

## Operation
- FSM has three states: IDLE, ISSUE and RESP. It leaves reset in IDLE.
- IDLE:
  - The arbiter picks one lane among the lanes with `reqN_valid` high.
  - If both lanes are valid, the grant goes to the lane that is not `last`. `last` resets to 1, so lane 0 wins the first contention.
  - `reqN_ready` is high only for the picked lane. It is combinational from valid, state and `last`, and is never high for both lanes.
  - On handshake, the FSM captures a, b and the lane index into the operand registers, sets `last` to the lane, and moves to ISSUE.
  - With no valid request, the FSM stays in IDLE.
- ISSUE (exactly one cycle):
  - `xu_a`/`xu_b` drive the captured operands.
  - At the clock edge, `xu_c` is captured into the result register of the owning lane. The FSM moves to RESP.
  - In the same cycle, `xu_c` is compared with `cap_a ^ cap_b`. On mismatch, `err` is set to 1 and `err_cnt` increments, saturating at 2^CNT_W−1.
- RESP:
  - `rspN_valid` is high for the owning lane only.
  - `rspN_c` holds stable until `rspN_ready` is sampled high.
  - On that handshake, the FSM returns to IDLE. There is no bypass from RESP to ISSUE.
- `xu_a`/`xu_b` hold the last captured operands outside ISSUE. They are 0 after reset.
- `err_clr` has priority over a same-cycle mismatch: the counter goes to 0 and `err` to 0.
- Reset mid-operation discards the in-flight pair. The discarded pair produces no response and is not counted.

## Timing
- Values after reset:
  - `req*_ready`: 0 (no valid requests yet).
  - `rsp*_valid`: 0.
  - `rsp*_c`: 0.
  - `xu_a`, `xu_b`: 0.
  - `err`: 0.
  - `err_cnt`: 0.
  - `last`: 1.
- Latency:
  - Request handshake in cycle T.
  - ISSUE in cycle T+1.
  - `rspN_valid` first high in cycle T+2.
  - With `rspN_ready` tied high, the next request handshake is possible in T+3.
- Peak throughput is one pair per 3 cycles.
- Alternation: with both lanes continuously valid, grants alternate 0,1,0,1…
- A lane whose request is not granted must hold valid and its data stable. It is served at the next IDLE if it is still valid.
- Response backpressure: the FSM stalls indefinitely in RESP. No new request is accepted while in RESP.

## Test plan
- Single lane 0, a=0x5A, b=0x0F, `rsp0_ready`=1 → `req0_ready` high at T; `xu_a`=0x5A and `xu_b`=0x0F at T+1; `rsp0_valid` high with `rsp0_c`=0x55 at T+2; lane 1 outputs stay 0.
- Both lanes valid from reset, with lane 0 = (0x01,0x02) and lane 1 = (0x10,0x20) held constant → lane 0 is served first (0x03), then lane 1 (0x30), then lane 0 again; grants strictly alternate.
- Backpressure: `rsp1_ready`=0 for 5 cycles after `rsp1_valid` rises → `rsp1_valid`/`rsp1_c` stay stable, `req0_ready` stays 0 despite `req0_valid`=1; lane 0 handshakes 1 cycle after `rsp1_ready` pulses.
- Faulty unit: `xu_c` forced to `xu_a & xu_b`, then 3 pairs with nonzero XOR/AND difference are sent → `err`=1, `err_cnt`=3; `err_clr` pulse → both 0 the next cycle. With CNT_W=2, 5 mismatches → `err_cnt`=3 (saturated).
- `rst_n` low during ISSUE for lane 1 → the next cycle shows all outputs at reset values, no `rsp1_valid`, and `err_cnt` unchanged at 0; the first post-reset contention grants lane 0.
- Simultaneous `err_clr` and mismatch in the same ISSUE cycle → `err_cnt`=0 and `err`=0 afterwards.
